// File: rtl/imem_boot_loader.sv
// UART boot loader: receives a sync/count/data/checksum packet, writes
// little-endian words into instruction memory and then releases the core.
module imem_boot_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int MAX_WORDS    = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  output logic        imem_we,
  output logic [7:0]  imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_rst,
  output logic        load_done,
  output logic        load_err,
  output logic        busy
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL      = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF      = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [7:0]    SYNC_BYTE = 8'hA5;
  localparam logic [7:0]    MAX_N     = 8'(MAX_WORDS);

  // Two-flop synchronizer plus one delay stage for falling-edge detection
  logic rx_meta, rx_sync, rx_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

  rx_state_t     rx_state, rx_state_nx;
  logic [CW-1:0] tick_cnt, tick_cnt_nx;
  logic [2:0]    bit_idx, bit_idx_nx;
  logic [7:0]    rx_byte, rx_byte_nx;
  logic          rx_valid, rx_valid_nx;
  logic          frame_err, frame_err_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state  <= R_IDLE;
      tick_cnt  <= '0;
      bit_idx   <= '0;
      rx_byte   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_state  <= rx_state_nx;
      tick_cnt  <= tick_cnt_nx;
      bit_idx   <= bit_idx_nx;
      rx_byte   <= rx_byte_nx;
      rx_valid  <= rx_valid_nx;
      frame_err <= frame_err_nx;
    end
  end

  always_comb begin
    rx_state_nx  = rx_state;
    tick_cnt_nx  = tick_cnt;
    bit_idx_nx   = bit_idx;
    rx_byte_nx   = rx_byte;
    rx_valid_nx  = 1'b0;
    frame_err_nx = 1'b0;
    case (rx_state)
      R_IDLE: begin
        tick_cnt_nx = '0;
        if (rx_prev && !rx_sync) rx_state_nx = R_START;
      end
      R_START: begin
        if (tick_cnt == HALF) begin
          tick_cnt_nx = '0;
          if (rx_sync) begin
            rx_state_nx = R_IDLE;
          end else begin
            rx_state_nx = R_DATA;
            bit_idx_nx  = '0;
          end
        end else begin
          tick_cnt_nx = tick_cnt + CW'(1);
        end
      end
      R_DATA: begin
        if (tick_cnt == FULL) begin
          tick_cnt_nx = '0;
          rx_byte_nx  = {rx_sync, rx_byte[7:1]};
          if (bit_idx == 3'd7) rx_state_nx = R_STOP;
          else                 bit_idx_nx  = bit_idx + 3'd1;
        end else begin
          tick_cnt_nx = tick_cnt + CW'(1);
        end
      end
      R_STOP: begin
        if (tick_cnt == FULL) begin
          tick_cnt_nx = '0;
          rx_state_nx = R_IDLE;
          if (rx_sync) rx_valid_nx  = 1'b1;
          else         frame_err_nx = 1'b1;
        end else begin
          tick_cnt_nx = tick_cnt + CW'(1);
        end
      end
      default: rx_state_nx = R_IDLE;
    endcase
  end

  typedef enum logic [2:0] {L_SYNC, L_COUNT, L_DATA, L_CSUM, L_DONE} ld_state_t;

  ld_state_t   ld_state, ld_state_nx;
  logic [6:0]  word_cnt, word_cnt_nx;
  logic [6:0]  word_idx, word_idx_nx;
  logic [1:0]  byte_idx, byte_idx_nx;
  logic [7:0]  csum, csum_nx;
  logic [23:0] word_buf, word_buf_nx;
  logic        imem_we_nx, core_rst_nx, load_done_nx, load_err_nx, busy_nx;
  logic [7:0]  imem_addr_nx;
  logic [31:0] imem_wdata_nx;
  logic        fail;

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_state   <= L_SYNC;
      word_cnt   <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      csum       <= '0;
      word_buf   <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_rst   <= 1'b1;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      ld_state   <= ld_state_nx;
      word_cnt   <= word_cnt_nx;
      word_idx   <= word_idx_nx;
      byte_idx   <= byte_idx_nx;
      csum       <= csum_nx;
      word_buf   <= word_buf_nx;
      imem_we    <= imem_we_nx;
      imem_addr  <= imem_addr_nx;
      imem_wdata <= imem_wdata_nx;
      core_rst   <= core_rst_nx;
      load_done  <= load_done_nx;
      load_err   <= load_err_nx;
      busy       <= busy_nx;
    end
  end

  always_comb begin
    ld_state_nx   = ld_state;
    word_cnt_nx   = word_cnt;
    word_idx_nx   = word_idx;
    byte_idx_nx   = byte_idx;
    csum_nx       = csum;
    word_buf_nx   = word_buf;
    imem_we_nx    = 1'b0;
    imem_addr_nx  = imem_addr;
    imem_wdata_nx = imem_wdata;
    core_rst_nx   = core_rst;
    load_done_nx  = load_done;
    load_err_nx   = load_err;
    busy_nx       = busy;
    fail          = 1'b0;
    case (ld_state)
      L_SYNC: begin
        if (rx_valid && rx_byte == SYNC_BYTE) begin
          load_err_nx = 1'b0;
          busy_nx     = 1'b1;
          word_idx_nx = '0;
          byte_idx_nx = '0;
          csum_nx     = '0;
          ld_state_nx = L_COUNT;
        end else if (frame_err) begin
          load_err_nx = 1'b1;
        end
      end
      L_COUNT: begin
        if (rx_valid) begin
          if (rx_byte == 8'd0 || rx_byte > MAX_N) begin
            fail = 1'b1;
          end else begin
            word_cnt_nx = rx_byte[6:0];
            ld_state_nx = L_DATA;
          end
        end else if (frame_err) begin
          fail = 1'b1;
        end
      end
      L_DATA: begin
        if (rx_valid) begin
          csum_nx     = csum ^ rx_byte;
          byte_idx_nx = byte_idx + 2'd1;
          case (byte_idx)
            2'd0: word_buf_nx[7:0]   = rx_byte;
            2'd1: word_buf_nx[15:8]  = rx_byte;
            2'd2: word_buf_nx[23:16] = rx_byte;
            default: begin
              // Last byte goes straight into the write data; no fourth buffer byte
              imem_we_nx    = 1'b1;
              imem_addr_nx  = {word_idx[5:0], 2'b00};
              imem_wdata_nx = {rx_byte, word_buf};
              word_idx_nx   = word_idx + 7'd1;
              if (word_idx + 7'd1 == word_cnt) ld_state_nx = L_CSUM;
            end
          endcase
        end else if (frame_err) begin
          fail = 1'b1;
        end
      end
      L_CSUM: begin
        if (rx_valid) begin
          if (rx_byte == csum) begin
            ld_state_nx  = L_DONE;
            load_done_nx = 1'b1;
            core_rst_nx  = 1'b0;
            busy_nx      = 1'b0;
          end else begin
            fail = 1'b1;
          end
        end else if (frame_err) begin
          fail = 1'b1;
        end
      end
      L_DONE: ;
      default: ld_state_nx = L_SYNC;
    endcase
    if (fail) begin
      load_err_nx = 1'b1;
      busy_nx     = 1'b0;
      ld_state_nx = L_SYNC;
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: UART-level directed and random packets compared
// against expected word writes and status outputs.
module tb_imem_boot_loader;

  localparam int CPB  = 4;
  localparam int MAXW = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uart_rx = 1'b1;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        core_rst, load_done, load_err, busy;

  imem_boot_loader #(.CLKS_PER_BIT(CPB), .MAX_WORDS(MAXW)) dut (
    .clk        (clk),
    .rst        (rst),
    .uart_rx    (uart_rx),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst   (core_rst),
    .load_done  (load_done),
    .load_err   (load_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [39:0] got_q[$];
  logic [39:0] exp_q[$];
  logic [7:0]  pkt[$];
  logic        prev_we = 1'b0;
  logic        consec  = 1'b0;

  // Capture every memory write away from the active edge
  always @(negedge clk) begin
    if (imem_we) got_q.push_back({imem_addr, imem_wdata});
    if (imem_we && prev_we) consec <= 1'b1;
    prev_we <= imem_we;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic send_bit(input logic b);
    uart_rx = b;
    tick(CPB);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    uart_rx = 1'b1;
    tick(2 * CPB);
  endtask

  task automatic send_range(input int first, input int last);
    for (int i = first; i <= last; i++) send_byte(pkt[i]);
  endtask

  // Directed single-word packet: word 0x00A00513, checksum 13^05^A0^00 = B6
  task automatic build_single(input logic [7:0] cs);
    pkt.delete();
    exp_q.delete();
    pkt.push_back(8'hA5); pkt.push_back(8'h01);
    pkt.push_back(8'h13); pkt.push_back(8'h05);
    pkt.push_back(8'hA0); pkt.push_back(8'h00);
    pkt.push_back(cs);
    exp_q.push_back({8'h00, 32'h00A00513});
  endtask

  // Random packet: word i lands at byte address 4*i; checksum is XOR of data bytes
  task automatic build_random(input int n, input logic [7:0] cs_flip);
    logic [31:0] w;
    logic [7:0]  cs;
    pkt.delete();
    exp_q.delete();
    cs = 8'h00;
    pkt.push_back(8'hA5);
    pkt.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      for (int k = 0; k < 4; k++) begin
        pkt.push_back(w[8*k +: 8]);
        cs = cs ^ w[8*k +: 8];
      end
      exp_q.push_back({8'(4 * i), w});
    end
    pkt.push_back(cs ^ cs_flip);
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check({tag, "_addr"}, 32'(got_q[i][39:32]), 32'(exp_q[i][39:32]));
      check({tag, "_data"}, got_q[i][31:0], exp_q[i][31:0]);
    end
  endtask

  task automatic check_done(input string tag);
    check({tag, "_done"},     32'(load_done), 32'(1));
    check({tag, "_core_rst"}, 32'(core_rst),  32'(0));
    check({tag, "_busy"},     32'(busy),      32'(0));
    check({tag, "_err"},      32'(load_err),  32'(0));
  endtask

  initial begin
    int n;

    do_reset();
    check("rst_we",    32'(imem_we),   32'(0));
    check("rst_addr",  32'(imem_addr), 32'(0));
    check("rst_wdata", imem_wdata,     32'(0));
    check("rst_core",  32'(core_rst),  32'(1));
    check("rst_done",  32'(load_done), 32'(0));
    check("rst_err",   32'(load_err),  32'(0));
    check("rst_busy",  32'(busy),      32'(0));

    // Good single word
    got_q.delete();
    build_single(8'hB6);
    send_range(0, 5);
    check("one_pre_core", 32'(core_rst),  32'(1));
    check("one_pre_busy", 32'(busy),      32'(1));
    check("one_pre_done", 32'(load_done), 32'(0));
    send_range(6, 6);
    check_writes("one");
    check_done("one");

    // Bytes after DONE are ignored
    got_q.delete();
    send_range(0, 6);
    check("after_done_we",   32'(got_q.size()), 32'(0));
    check("after_done_done", 32'(load_done),    32'(1));
    check("after_done_core", 32'(core_rst),     32'(0));

    // Bad checksum, then retransmission
    do_reset();
    got_q.delete();
    build_single(8'hB7);
    send_range(0, 6);
    check_writes("badcs");
    check("badcs_err",  32'(load_err),  32'(1));
    check("badcs_core", 32'(core_rst),  32'(1));
    check("badcs_done", 32'(load_done), 32'(0));
    check("badcs_busy", 32'(busy),      32'(0));
    got_q.delete();
    build_single(8'hB6);
    send_range(0, 6);
    check_writes("resend");
    check_done("resend");

    // Bad counts: zero and MAX_WORDS+1
    do_reset();
    got_q.delete();
    send_byte(8'hA5);
    check("cnt0_busy_pre", 32'(busy), 32'(1));
    send_byte(8'h00);
    check("cnt0_err",  32'(load_err), 32'(1));
    check("cnt0_busy", 32'(busy),     32'(0));
    send_byte(8'hA5);
    check("cnt_err_cleared", 32'(load_err), 32'(0));
    send_byte(8'(MAXW + 1));
    check("cnt65_err",  32'(load_err),     32'(1));
    check("cnt_no_we",  32'(got_q.size()), 32'(0));
    check("cnt_core",   32'(core_rst),     32'(1));

    // Short glitch in L_COUNT must not produce a byte
    do_reset();
    got_q.delete();
    build_single(8'hB6);
    send_byte(8'hA5);
    uart_rx = 1'b0;
    tick(2);
    uart_rx = 1'b1;
    tick(4 * CPB);
    check("glitch_err",  32'(load_err), 32'(0));
    check("glitch_busy", 32'(busy),     32'(1));
    send_range(1, 6);
    check_writes("glitch");
    check_done("glitch");

    // Framing error during data aborts the packet
    do_reset();
    got_q.delete();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33, 1'b0);
    check("frame_err",  32'(load_err),     32'(1));
    check("frame_busy", 32'(busy),         32'(0));
    check("frame_core", 32'(core_rst),     32'(1));
    check("frame_no_we", 32'(got_q.size()), 32'(0));
    build_single(8'hB6);
    send_range(0, 6);
    check_writes("frame_retry");
    check_done("frame_retry");

    // Reset after two data bytes discards the partial word
    do_reset();
    got_q.delete();
    build_single(8'hB6);
    send_range(0, 3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("midrst_busy", 32'(busy),     32'(0));
    check("midrst_core", 32'(core_rst), 32'(1));
    check("midrst_we",   32'(imem_we),  32'(0));
    send_range(4, 6);
    build_random(2, 8'h00);
    send_range(0, pkt.size() - 1);
    check_writes("midrst");
    check_done("midrst");

    // Random packets: three words, maximum depth, random sizes, one bad checksum
    for (int t = 0; t < 5; t++) begin
      n = (t == 0) ? 3 : (t == 1) ? MAXW : int'($urandom_range(1, 8));
      do_reset();
      got_q.delete();
      build_random(n, (t == 4) ? 8'(1 << $urandom_range(0, 7)) : 8'h00);
      send_range(0, pkt.size() - 1);
      check_writes("rand");
      if (t == 4) begin
        check("rand_bad_err",  32'(load_err), 32'(1));
        check("rand_bad_core", 32'(core_rst), 32'(1));
      end else begin
        check_done("rand");
      end
    end

    check("no_back_to_back_we", 32'(consec), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
